// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo back end: opcodes, ROB sizing and the
// reservation-station entry state.
package tomasulo_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int TAG_W     = 3;
   localparam int DATA_W    = 16;
   localparam int OPC_W     = 4;

   localparam logic [OPC_W-1:0] OPC_ADD = 4'h0;
   localparam logic [OPC_W-1:0] OPC_SUB = 4'h1;
   localparam logic [OPC_W-1:0] OPC_MUL = 4'h2;
   localparam logic [OPC_W-1:0] OPC_DIV = 4'h3;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RDY  = 2'd2
   } entry_st_e;

endpackage

// File: rtl/rs_issue_sched_if.sv
// Decode allocation, CDB snoop and functional-unit dispatch bundle of one
// reservation station. The scheduler uses the slave view.
interface rs_issue_sched_if #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 3,
   parameter int DATA_W      = 16,
   parameter int OPC_W       = 4
);
   localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

   logic              alloc_valid;
   logic              alloc_ready;
   logic [OPC_W-1:0]  alloc_opcode;
   logic [TAG_W-1:0]  alloc_dest_tag;
   logic              alloc_src1_rdy;
   logic [DATA_W-1:0] alloc_src1;
   logic              alloc_src2_rdy;
   logic [DATA_W-1:0] alloc_src2;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              fu_valid;
   logic              fu_ready;
   logic [OPC_W-1:0]  fu_opcode;
   logic [DATA_W-1:0] fu_src1;
   logic [DATA_W-1:0] fu_src2;
   logic [TAG_W-1:0]  fu_dest_tag;
   logic [CNT_W-1:0]  used_count;

   modport master (
      output alloc_valid, alloc_opcode, alloc_dest_tag, alloc_src1_rdy, alloc_src1,
             alloc_src2_rdy, alloc_src2, cdb_valid, cdb_tag, cdb_data, fu_ready,
      input  alloc_ready, fu_valid, fu_opcode, fu_src1, fu_src2, fu_dest_tag, used_count
   );

   modport slave (
      input  alloc_valid, alloc_opcode, alloc_dest_tag, alloc_src1_rdy, alloc_src1,
             alloc_src2_rdy, alloc_src2, cdb_valid, cdb_tag, cdb_data, fu_ready,
      output alloc_ready, fu_valid, fu_opcode, fu_src1, fu_src2, fu_dest_tag, used_count
   );

endinterface

// File: rtl/rs_oldest_pick.sv
// Oldest-first picker: grants the eligible entry that is older than every
// other eligible entry according to the age matrix (row i bit j = i older than j).
module rs_oldest_pick #(
   parameter int NUM_ENTRIES = 4
) (
   input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age,
   input  logic [NUM_ENTRIES-1:0]                  elig,
   output logic [NUM_ENTRIES-1:0]                  grant,
   output logic                                    valid
);

   // An eligible entry wins unless some other eligible entry is older
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         grant[i] = elig[i];
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            grant[i] = grant[i] & ~((j != i) & elig[j] & ~age[i][j]);
         end
      end
      valid = |elig;
   end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: holds decoded ops, snoops the CDB for missing
// operands and issues the oldest ready entry to the functional unit.
module rs_issue_sched #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 3,
   parameter int DATA_W      = 16,
   parameter int OPC_W       = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic             flush,
   rs_issue_sched_if.slave bus
);
   import tomasulo_pkg::*;

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

   entry_st_e [NUM_ENTRIES-1:0]              st_r;
   logic [NUM_ENTRIES-1:0][OPC_W-1:0]        opc_r;
   logic [NUM_ENTRIES-1:0][TAG_W-1:0]        dest_r;
   logic [NUM_ENTRIES-1:0]                   s1_rdy_r, s2_rdy_r;
   logic [NUM_ENTRIES-1:0][DATA_W-1:0]       s1_r, s2_r;
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  age_r, age_nxt_s;
   logic                                     lock_r;
   logic [IDX_W-1:0]                         lock_idx_r;

   logic [NUM_ENTRIES-1:0] free_s, rdy_s, grant_s, cap1_s, cap2_s;
   logic                   pick_valid_s, alloc_fire_s, disp_fire_s;
   logic [IDX_W-1:0]       alloc_idx_s, grant_idx_s, sel_idx_s;
   logic [CNT_W-1:0]       used_s;
   logic                   a1_hit_s, a2_hit_s, a1_rdy_s, a2_rdy_s;
   logic [DATA_W-1:0]      a1_val_s, a2_val_s;

   // Occupancy, free-slot search, CDB wakeup matches and alloc-time bypass
   always_comb begin
      free_s      = '0;
      rdy_s       = '0;
      cap1_s      = '0;
      cap2_s      = '0;
      used_s      = '0;
      alloc_idx_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         free_s[i] = (st_r[i] == ST_FREE);
         rdy_s[i]  = (st_r[i] == ST_RDY);
         used_s    = used_s + CNT_W'(!free_s[i]);
         cap1_s[i] = (st_r[i] == ST_WAIT) & ~s1_rdy_r[i] & bus.cdb_valid
                     & (s1_r[i][TAG_W-1:0] == bus.cdb_tag);
         cap2_s[i] = (st_r[i] == ST_WAIT) & ~s2_rdy_r[i] & bus.cdb_valid
                     & (s2_r[i][TAG_W-1:0] == bus.cdb_tag);
      end
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         alloc_idx_s = free_s[i] ? IDX_W'(i) : alloc_idx_s;
      end
      bus.used_count  = used_s;
      bus.alloc_ready = (used_s < CNT_W'(NUM_ENTRIES));
      alloc_fire_s    = bus.alloc_valid & bus.alloc_ready;
      a1_hit_s = ~bus.alloc_src1_rdy & bus.cdb_valid & (bus.alloc_src1[TAG_W-1:0] == bus.cdb_tag);
      a2_hit_s = ~bus.alloc_src2_rdy & bus.cdb_valid & (bus.alloc_src2[TAG_W-1:0] == bus.cdb_tag);
      a1_rdy_s = bus.alloc_src1_rdy | a1_hit_s;
      a2_rdy_s = bus.alloc_src2_rdy | a2_hit_s;
      a1_val_s = a1_hit_s ? bus.cdb_data : bus.alloc_src1;
      a2_val_s = a2_hit_s ? bus.cdb_data : bus.alloc_src2;
   end

   rs_oldest_pick #(.NUM_ENTRIES(NUM_ENTRIES)) u_pick (
      .age   (age_r),
      .elig  (rdy_s),
      .grant (grant_s),
      .valid (pick_valid_s)
   );

   // Dispatch selection; a stalled offer stays pinned to its locked index
   always_comb begin
      grant_idx_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         grant_idx_s = grant_s[i] ? IDX_W'(i) : grant_idx_s;
      end
      sel_idx_s       = lock_r ? lock_idx_r : grant_idx_s;
      disp_fire_s     = pick_valid_s & bus.fu_ready;
      bus.fu_valid    = pick_valid_s;
      bus.fu_opcode   = pick_valid_s ? opc_r[sel_idx_s]  : '0;
      bus.fu_src1     = pick_valid_s ? s1_r[sel_idx_s]   : '0;
      bus.fu_src2     = pick_valid_s ? s2_r[sel_idx_s]   : '0;
      bus.fu_dest_tag = pick_valid_s ? dest_r[sel_idx_s] : '0;
   end

   // New allocation becomes youngest: everyone is older than it, it is older than nobody
   always_comb begin
      age_nxt_s = age_r;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         age_nxt_s[i][alloc_idx_s] = alloc_fire_s ? 1'b1 : age_r[i][alloc_idx_s];
      end
      age_nxt_s[alloc_idx_s] = alloc_fire_s ? '0 : age_nxt_s[alloc_idx_s];
   end

   // Entry state, operand capture, allocation, age matrix and dispatch lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) st_r[i] <= ST_FREE;
         opc_r      <= '0;
         dest_r     <= '0;
         s1_rdy_r   <= '0;
         s2_rdy_r   <= '0;
         s1_r       <= '0;
         s2_r       <= '0;
         age_r      <= '0;
         lock_r     <= 1'b0;
         lock_idx_r <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) st_r[i] <= ST_FREE;
         age_r      <= '0;
         lock_r     <= 1'b0;
         lock_idx_r <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cap1_s[i]) begin
               s1_r[i]     <= bus.cdb_data;
               s1_rdy_r[i] <= 1'b1;
            end
            if (cap2_s[i]) begin
               s2_r[i]     <= bus.cdb_data;
               s2_rdy_r[i] <= 1'b1;
            end
            if ((st_r[i] == ST_WAIT) && (s1_rdy_r[i] | cap1_s[i]) && (s2_rdy_r[i] | cap2_s[i])) begin
               st_r[i] <= ST_RDY;
            end
         end
         if (disp_fire_s) st_r[sel_idx_s] <= ST_FREE;
         if (alloc_fire_s) begin
            st_r[alloc_idx_s]     <= (a1_rdy_s & a2_rdy_s) ? ST_RDY : ST_WAIT;
            opc_r[alloc_idx_s]    <= bus.alloc_opcode;
            dest_r[alloc_idx_s]   <= bus.alloc_dest_tag;
            s1_rdy_r[alloc_idx_s] <= a1_rdy_s;
            s2_rdy_r[alloc_idx_s] <= a2_rdy_s;
            s1_r[alloc_idx_s]     <= a1_val_s;
            s2_r[alloc_idx_s]     <= a2_val_s;
         end
         age_r <= age_nxt_s;
         if (disp_fire_s) begin
            lock_r <= 1'b0;
         end else if (pick_valid_s) begin
            lock_r     <= 1'b1;
            lock_idx_r <= sel_idx_s;
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: expected dispatches are queued by the
// stimulus and popped by an independent monitor on every FU acceptance.
module tb_rs_issue_sched;
   import tomasulo_pkg::*;

   typedef struct packed {
      logic [3:0]  opc;
      logic [15:0] s1;
      logic [15:0] s2;
      logic [2:0]  tag;
   } disp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   checks = 0;
   int   errors = 0;
   disp_t exp_q[$];
   disp_t held;
   disp_t act;
   logic  prev_stall = 1'b0;

   rs_issue_sched_if #(.NUM_ENTRIES(4), .TAG_W(3), .DATA_W(16), .OPC_W(4)) bus ();

   rs_issue_sched #(.NUM_ENTRIES(4), .TAG_W(3), .DATA_W(16), .OPC_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: hold check on stalled offers, pop-and-compare on acceptance
   always @(negedge clk) begin
      act = {bus.fu_opcode, bus.fu_src1, bus.fu_src2, bus.fu_dest_tag};
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!bus.fu_valid || act !== held) begin
               errors++;
               $display("FAIL hold: got valid=%0b %h required valid=1 %h", bus.fu_valid, act, held);
            end
         end
         if (bus.fu_valid && bus.fu_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL dispatch: got unexpected %h required none", act);
            end else begin
               disp_t e;
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL dispatch: got %h required %h", act, e);
               end
            end
         end
         prev_stall = bus.fu_valid && !bus.fu_ready && !flush;
         held       = act;
      end
   end

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, a, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [3:0] opc, input logic [2:0] dest,
                           input logic r1, input logic [15:0] s1,
                           input logic r2, input logic [15:0] s2);
      bus.alloc_valid    = 1'b1;
      bus.alloc_opcode   = opc;
      bus.alloc_dest_tag = dest;
      bus.alloc_src1_rdy = r1;
      bus.alloc_src1     = s1;
      bus.alloc_src2_rdy = r2;
      bus.alloc_src2     = s2;
      cyc();
      bus.alloc_valid = 1'b0;
   endtask

   task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = tag;
      bus.cdb_data  = data;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.alloc_valid = 1'b0; bus.alloc_opcode = '0; bus.alloc_dest_tag = '0;
      bus.alloc_src1_rdy = 1'b0; bus.alloc_src1 = '0;
      bus.alloc_src2_rdy = 1'b0; bus.alloc_src2 = '0;
      bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
      bus.fu_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_fu_valid", bus.fu_valid, 0);
      chk("rst_used", bus.used_count, 0);
      chk("rst_alloc_ready", bus.alloc_ready, 1);
      chk("rst_payload", {bus.fu_opcode, bus.fu_src1, bus.fu_src2, bus.fu_dest_tag}, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Ready ADD dispatches the cycle after allocation
      exp_q.push_back('{OPC_ADD, 16'h0005, 16'h0007, 3'd3});
      do_alloc(OPC_ADD, 3'd3, 1'b1, 16'h0005, 1'b1, 16'h0007);
      @(negedge clk); chk("t1_fu_valid", bus.fu_valid, 1);
      @(negedge clk); chk("t1_used_after", bus.used_count, 0);
      cyc();

      // SUB waits on tag 2, woken by the CDB two cycles later
      exp_q.push_back('{OPC_SUB, 16'h0009, 16'h0001, 3'd4});
      do_alloc(OPC_SUB, 3'd4, 1'b0, 16'h0002, 1'b1, 16'h0001);
      cyc();
      cdb(3'd2, 16'h0009);
      @(negedge clk); chk("t2_no_bypass_dispatch", bus.fu_valid, 0);
      cyc();
      bus.cdb_valid = 1'b0;
      @(negedge clk); chk("t2_woken_src1", bus.fu_src1, 16'h0009);
      drain("t2_drain");

      // Two entries wait on tag 6; older goes first
      exp_q.push_back('{OPC_ADD, 16'h0066, 16'h0011, 3'd1});
      exp_q.push_back('{OPC_SUB, 16'h0022, 16'h0066, 3'd2});
      do_alloc(OPC_ADD, 3'd1, 1'b0, 16'h0006, 1'b1, 16'h0011);
      do_alloc(OPC_SUB, 3'd2, 1'b1, 16'h0022, 1'b0, 16'h0006);
      cdb(3'd6, 16'h0066);
      cyc();
      bus.cdb_valid = 1'b0;
      @(negedge clk); chk("t3_first_tag", bus.fu_dest_tag, 1);
      @(negedge clk); chk("t3_second_tag", bus.fu_dest_tag, 2);
      drain("t3_drain");

      // Stalled younger offer holds while an older entry wakes up
      bus.fu_ready = 1'b0;
      exp_q.push_back('{OPC_MUL, 16'h0004, 16'h0005, 3'd6});
      exp_q.push_back('{OPC_ADD, 16'h0077, 16'h0003, 3'd5});
      do_alloc(OPC_ADD, 3'd5, 1'b0, 16'h0007, 1'b1, 16'h0003);
      do_alloc(OPC_MUL, 3'd6, 1'b1, 16'h0004, 1'b1, 16'h0005);
      cdb(3'd7, 16'h0077);
      @(negedge clk); chk("t4_stall_c1", bus.fu_dest_tag, 6);
      cyc();
      bus.cdb_valid = 1'b0;
      @(negedge clk); chk("t4_stall_c2", bus.fu_dest_tag, 6);
      cyc();
      @(negedge clk); chk("t4_stall_c3", bus.fu_dest_tag, 6);
      cyc();
      bus.fu_ready = 1'b1;
      drain("t4_drain");

      // Fill the station, then dispatch with a same-cycle allocation attempt
      bus.fu_ready = 1'b0;
      exp_q.push_back('{OPC_ADD, 16'h0001, 16'h0002, 3'd0});
      exp_q.push_back('{OPC_MUL, 16'h0070, 16'h0071, 3'd7});
      exp_q.push_back('{OPC_SUB, 16'h0033, 16'h0012, 3'd1});
      exp_q.push_back('{OPC_MUL, 16'h0021, 16'h0033, 3'd2});
      exp_q.push_back('{OPC_DIV, 16'h0033, 16'h0033, 3'd3});
      do_alloc(OPC_ADD, 3'd0, 1'b1, 16'h0001, 1'b1, 16'h0002);
      do_alloc(OPC_SUB, 3'd1, 1'b0, 16'h0003, 1'b1, 16'h0012);
      do_alloc(OPC_MUL, 3'd2, 1'b1, 16'h0021, 1'b0, 16'h0003);
      do_alloc(OPC_DIV, 3'd3, 1'b0, 16'h0003, 1'b0, 16'h0003);
      bus.alloc_valid = 1'b1; bus.alloc_opcode = OPC_DIV; bus.alloc_dest_tag = 3'd5;
      bus.alloc_src1_rdy = 1'b1; bus.alloc_src1 = 16'hDEAD;
      bus.alloc_src2_rdy = 1'b1; bus.alloc_src2 = 16'hBEEF;
      @(negedge clk);
      chk("t5_full_ready", bus.alloc_ready, 0);
      chk("t5_full_used", bus.used_count, 4);
      cyc();
      bus.alloc_opcode = OPC_MUL; bus.alloc_dest_tag = 3'd7;
      bus.alloc_src1 = 16'h0070; bus.alloc_src2 = 16'h0071;
      bus.fu_ready = 1'b1;
      @(negedge clk);
      chk("t5_ignored_used", bus.used_count, 4);
      chk("t5_same_cycle_ready", bus.alloc_ready, 0);
      cyc();
      @(negedge clk);
      chk("t5_after_disp_ready", bus.alloc_ready, 1);
      chk("t5_after_disp_used", bus.used_count, 3);
      cyc();
      bus.alloc_valid = 1'b0;
      @(negedge clk); chk("t5_realloc_used", bus.used_count, 4);
      cyc();
      cdb(3'd3, 16'h0033);
      cyc();
      bus.cdb_valid = 1'b0;
      drain("t5_drain");

      // Alloc/CDB bypass, flush while stalled, then async reset mid-handshake
      bus.fu_ready = 1'b0;
      cdb(3'd5, 16'h00AA);
      do_alloc(OPC_ADD, 3'd2, 1'b0, 16'h0005, 1'b1, 16'h0001);
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      chk("t6_bypass_valid", bus.fu_valid, 1);
      chk("t6_bypass_src1", bus.fu_src1, 16'h00AA);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      chk("t6_flush_used", bus.used_count, 0);
      chk("t6_flush_valid", bus.fu_valid, 0);
      cyc();
      do_alloc(OPC_MUL, 3'd1, 1'b1, 16'h0005, 1'b1, 16'h0006);
      @(negedge clk); chk("t6_pending_valid", bus.fu_valid, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_fu_valid", bus.fu_valid, 0);
      chk("t6_rst_used", bus.used_count, 0);
      chk("t6_rst_alloc_ready", bus.alloc_ready, 1);
      chk("t6_rst_payload", {bus.fu_opcode, bus.fu_src1, bus.fu_src2, bus.fu_dest_tag}, 0);
      cyc();
      rst_n = 1'b1;
      bus.fu_ready = 1'b1;
      @(negedge clk); chk("t6_post_rst_valid", bus.fu_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Per-reservation-station scheduler. Holds decoded operations from the decode stage, captures operands broadcast on the common data bus (CDB), and picks the oldest ready entry for the station's functional unit.
- Dispatch uses a valid/ready handshake.
- Instantiated once for the add/sub station and once for the mul/div station; entry counts are reported back to decode for stall decisions.

Parameters:
- NUM_ENTRIES, 4, reservation station depth (2..8)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 16, operand/result width
- OPC_W, 4, opcode width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries
- alloc_valid  in  1  decode presents an operation
- alloc_ready  out  1  a free entry exists
- alloc_opcode  in  OPC_W  operation code
- alloc_dest_tag  in  TAG_W  ROB tag of the result
- alloc_src1_rdy  in  1  1 = src1 holds a value, 0 = src1 holds a ROB tag
- alloc_src1  in  DATA_W  value, or tag in low TAG_W bits
- alloc_src2_rdy  in  1  same as src1, for src2
- alloc_src2  in  DATA_W  same as src1, for src2
- cdb_valid  in  1  result broadcast this cycle
- cdb_tag  in  TAG_W  ROB tag of the broadcast
- cdb_data  in  DATA_W  broadcast value
- fu_valid  out  1  dispatch request
- fu_ready  in  1  functional unit accepts
- fu_opcode  out  OPC_W  dispatched opcode
- fu_src1  out  DATA_W  dispatched operand 1
- fu_src2  out  DATA_W  dispatched operand 2
- fu_dest_tag  out  TAG_W  dispatched ROB tag
- used_count  out  $clog2(NUM_ENTRIES)+1  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - all entries FREE, age matrix cleared, lock cleared
  - fu_valid=0, used_count=0, alloc_ready=1
  - all fu_* payload outputs 0
  - reset mid-handshake drops the pending dispatch; no partial state survives
- Entry states:
  - FREE -> WAIT on alloc if either source is unready
  - FREE -> RDY on alloc if both sources are ready
  - WAIT -> RDY when the last missing operand is captured from the CDB
  - RDY -> FREE on the edge where it is dispatched (fu_valid & fu_ready)
- Allocation:
  - alloc_ready = (used_count < NUM_ENTRIES); registered view only, same-cycle dispatch does not raise it
  - on alloc_valid & alloc_ready, the lowest-index FREE entry is written
  - new entry is youngest in the age matrix
- Alloc/CDB bypass: if cdb_valid and an unready alloc source tag equals cdb_tag in the same cycle, that source is stored as ready with cdb_data.
- CDB capture:
  - every WAIT entry compares both source tags against cdb_tag; matches latch cdb_data and set ready
  - one broadcast per cycle; matching on both sources is legal
  - an entry woken by the CDB is eligible from the next cycle; there is no same-cycle CDB-to-dispatch path
- Selection:
  - among RDY entries, pick the oldest per the age matrix
  - fu_* are driven combinationally from the selected entry
  - latency: alloc with both sources ready at edge N -> fu_valid high in cycle N+1
- Handshake:
  - once fu_valid=1 with fu_ready=0, the selected index is locked
  - fu_* stay stable until acceptance, even if an older entry becomes RDY
  - lock releases on acceptance
- Simultaneous events: alloc, CDB capture and dispatch may all occur on one edge.
  - used_count = old + alloc_fire - dispatch_fire
  - the dispatched entry cannot be reallocated on that same edge
- Full: alloc_ready=0; alloc_valid is ignored.
- Empty: fu_valid=0.
- Flush:
  - next edge frees all entries, clears lock, used_count=0
  - flush has priority over alloc and dispatch on that edge
- Age matrix:
  - NUM_ENTRIES x NUM_ENTRIES bits; row i bit j = i older than j
  - on alloc of k: set column k, clear row k
  - free entries are masked out of selection

Decomposition:
- Shared package tomasulo_pkg: opcode constants (ADD=4'h0, SUB=4'h1, MUL=4'h2, DIV=4'h3), ROB depth 8, TAG_W, DATA_W, entry-state enum {FREE, WAIT, RDY}.
- One sub-module, rs_oldest_pick:
  - inputs: age matrix and eligible mask
  - outputs: one-hot grant and valid
  - purely combinational

Test Plan:
- Reset then alloc ADD (dest 3, src1=5, src2=7, both ready), fu_ready=1 -> cycle after alloc: fu_valid=1, opcode 0, src 5/7, tag 3; next cycle used_count=0.
- Alloc SUB (dest 4) with src1 tag 2 unready, src2=1 ready; two cycles later cdb tag 2 data 9 -> fu_valid rises the cycle after the broadcast with src1=9.
- Alloc entries A (tag 1) then B (tag 2), both waiting on tag 6; cdb tag 6 -> A dispatched first, B next cycle.
- fu_ready=0 for 3 cycles while an older entry becomes ready -> fu_* hold the original entry; the older entry dispatches after acceptance.
- Fill 4 entries -> alloc_ready=0 and an extra alloc_valid is ignored; dispatch one with a same-cycle alloc_valid -> not accepted; accepted next cycle.
- Alloc unready src tag 5 with same-cycle cdb tag 5 data 0x00AA -> captured; then flush mid-stall -> used_count=0, fu_valid=0; assert rst_n low mid-handshake -> all outputs at reset values immediately.
